// File: rtl/bldc_deadtime_commutator_pkg.sv
// Shared bldc types: direction/hall encodings, phase masks, dead-time FSM
// states and the hall-to-sector mapping.
package bldc_deadtime_commutator_pkg;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_CW    = 2'd1,
        DIR_CCW   = 2'd2,
        DIR_BRAKE = 2'd3
    } rotation_direction_t;

    // Hall pins are {A,B,C}, A in the MSB.
    typedef enum logic [2:0] {
        HALL_C  = 3'b001,
        HALL_B  = 3'b010,
        HALL_BC = 3'b011,
        HALL_A  = 3'b100,
        HALL_AC = 3'b101,
        HALL_AB = 3'b110
    } hall_states_t;

    // One-hot phase masks inside a 3-bit hi or lo group, ordered {A,B,C}.
    localparam logic [2:0] PHASE_A = 3'b100;
    localparam logic [2:0] PHASE_B = 3'b010;
    localparam logic [2:0] PHASE_C = 3'b001;

    typedef enum logic {
        DT_RUN  = 1'b0,
        DT_DEAD = 1'b1
    } dt_state_t;

    localparam logic [2:0] SECTOR_INVALID = 3'd7;

    // Electrical sector 0..5 for a valid hall code, SECTOR_INVALID otherwise.
    function automatic logic [2:0] hall_to_sector(input logic [2:0] hall);
        logic [2:0] sec;
        case (hall)
            HALL_AC: sec = 3'd0;
            HALL_A:  sec = 3'd1;
            HALL_AB: sec = 3'd2;
            HALL_B:  sec = 3'd3;
            HALL_BC: sec = 3'd4;
            HALL_C:  sec = 3'd5;
            default: sec = SECTOR_INVALID;
        endcase
        return sec;
    endfunction

endpackage

// File: rtl/bldc_deadtime_commutator_if.sv
// Control/status bundle of the dead-time commutator.
//   master: drives dir, hall_in, fault_clear; observes gate and status outputs
//   slave : the commutator itself
interface bldc_deadtime_commutator_if;
    bldc_deadtime_commutator_pkg::rotation_direction_t dir;
    logic [2:0] hall_in;
    logic       fault_clear;
    logic [5:0] phase_enable;
    logic [2:0] sector;
    logic       commutated;
    logic       hall_fault;
    logic       in_deadtime;

    modport master (
        output dir, hall_in, fault_clear,
        input  phase_enable, sector, commutated, hall_fault, in_deadtime
    );

    modport slave (
        input  dir, hall_in, fault_clear,
        output phase_enable, sector, commutated, hall_fault, in_deadtime
    );
endinterface

// File: rtl/bldc_hall_filter.sv
// Hall input conditioning: 2-flop synchroniser followed by a stability
// counter; a new code is accepted after HALL_FILTER identical samples.
//   clk, rst_n  : clock, async active-low reset
//   hall_in     : raw hall pins {A,B,C}, asynchronous to clk
//   hall_acc    : last accepted hall code (registered)
//   hall_valid  : set once the first code has been accepted (registered)
module bldc_hall_filter #(
    parameter int unsigned HALL_FILTER = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] hall_in,
    output logic [2:0] hall_acc,
    output logic       hall_valid
);

    localparam int unsigned        FLT_W   = $clog2(HALL_FILTER + 1);
    localparam logic [FLT_W-1:0]   FLT_MAX = FLT_W'(HALL_FILTER);

    logic [2:0]       sync1_q;
    logic [2:0]       hall_s_q;
    logic [2:0]       cand_q;
    logic [FLT_W-1:0] cnt_q;
    logic [1:0]       primed_q;

    // Filtering is held off until the synchroniser carries real pin samples,
    // so its reset contents are never mistaken for a stable 3'b000 code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            hall_s_q   <= '0;
            primed_q   <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            hall_acc   <= '0;
            hall_valid <= 1'b0;
        end else begin
            sync1_q  <= hall_in;
            hall_s_q <= sync1_q;
            primed_q <= {primed_q[0], 1'b1};
            if (primed_q[1]) begin
                if (hall_s_q != cand_q) begin
                    cand_q <= hall_s_q;
                    cnt_q  <= FLT_W'(1);
                    if (FLT_MAX == FLT_W'(1)) begin
                        hall_acc   <= hall_s_q;
                        hall_valid <= 1'b1;
                    end
                end else if (cnt_q < FLT_MAX) begin
                    cnt_q <= cnt_q + FLT_W'(1);
                    if (cnt_q + FLT_W'(1) == FLT_MAX) begin
                        hall_acc   <= cand_q;
                        hall_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/bldc_deadtime_commutator.sv
// Six-step BLDC commutator with hall filtering, invalid-hall fault latch,
// sector reporting and dead-time insertion on every gate turn-on.
//   clk, rst_n : clock, async active-low reset
//   bus.dir          : NONE / CW / CCW / BRAKE
//   bus.hall_in      : raw hall pins {A,B,C}
//   bus.fault_clear  : pulse to clear hall_fault once the hall is valid again
//   bus.phase_enable : {hi_A,hi_B,hi_C,lo_A,lo_B,lo_C}
//   bus.sector       : accepted sector 0..5, 7 when invalid
//   bus.commutated   : pulse when a new non-zero target is applied
//   bus.hall_fault   : sticky invalid-hall flag
//   bus.in_deadtime  : high while gate turn-on is being delayed
module bldc_deadtime_commutator
    import bldc_deadtime_commutator_pkg::*;
#(
    parameter int unsigned DEADTIME_CYCLES = 16,
    parameter int unsigned HALL_FILTER     = 4
) (
    input logic                         clk,
    input logic                         rst_n,
    bldc_deadtime_commutator_if.slave   bus
);

    localparam int unsigned CNT_W =
        $clog2(((DEADTIME_CYCLES > HALL_FILTER) ? DEADTIME_CYCLES : HALL_FILTER) + 1);
    localparam logic [CNT_W-1:0] DT_RELOAD =
        (DEADTIME_CYCLES > 0) ? CNT_W'(DEADTIME_CYCLES - 1) : '0;

    logic [2:0]       hall_acc;
    logic             hall_valid;
    logic [2:0]       sector_q;
    logic             fault_q;
    logic             fault_set_c;
    logic [5:0]       target_c;
    logic             turn_on_c;
    logic             tgt_changed_c;

    dt_state_t        state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [5:0]       pe_q, pe_n;
    logic [5:0]       tgt_q;
    logic             comm_q, comm_n;
    logic             dead_q;

    bldc_hall_filter #(
        .HALL_FILTER (HALL_FILTER)
    ) u_hall_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .hall_in    (bus.hall_in),
        .hall_acc   (hall_acc),
        .hall_valid (hall_valid)
    );

    // A motoring command with an accepted all-low/all-high hall code is a fault.
    assign fault_set_c = hall_valid
                       && ((hall_acc == 3'b000) || (hall_acc == 3'b111))
                       && ((bus.dir == DIR_CW) || (bus.dir == DIR_CCW));

    // Sector register and sticky fault; setting wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sector_q <= SECTOR_INVALID;
            fault_q  <= 1'b0;
        end else begin
            sector_q <= hall_to_sector(hall_acc);
            if (fault_set_c) begin
                fault_q <= 1'b1;
            end else if (bus.fault_clear) begin
                fault_q <= 1'b0;
            end
        end
    end

    // Commutation table: {hi group, lo group} for the requested mode.
    always_comb begin
        target_c = '0;
        if (!fault_q) begin
            case (bus.dir)
                DIR_BRAKE: target_c = 6'b000111;
                DIR_CW: begin
                    case (sector_q)
                        3'd0:    target_c = {PHASE_A, PHASE_B};
                        3'd1:    target_c = {PHASE_A, PHASE_C};
                        3'd2:    target_c = {PHASE_B, PHASE_C};
                        3'd3:    target_c = {PHASE_B, PHASE_A};
                        3'd4:    target_c = {PHASE_C, PHASE_A};
                        3'd5:    target_c = {PHASE_C, PHASE_B};
                        default: target_c = '0;
                    endcase
                end
                DIR_CCW: begin
                    case (sector_q)
                        3'd0:    target_c = {PHASE_B, PHASE_A};
                        3'd1:    target_c = {PHASE_C, PHASE_A};
                        3'd2:    target_c = {PHASE_C, PHASE_B};
                        3'd3:    target_c = {PHASE_A, PHASE_B};
                        3'd4:    target_c = {PHASE_A, PHASE_C};
                        3'd5:    target_c = {PHASE_B, PHASE_C};
                        default: target_c = '0;
                    endcase
                end
                default: target_c = '0;
            endcase
        end
    end

    assign turn_on_c     = |(target_c & ~pe_q);
    assign tgt_changed_c = (target_c != tgt_q);

    // Dead-time next state: turn-offs apply at once, turn-ons wait out the
    // dead interval, which restarts whenever the target asks for more bits.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        pe_n    = pe_q;
        comm_n  = 1'b0;
        if (DEADTIME_CYCLES == 0) begin
            state_n = DT_RUN;
            pe_n    = target_c;
            comm_n  = (target_c != pe_q) && (|target_c);
        end else begin
            case (state_q)
                DT_RUN: begin
                    if (target_c != pe_q) begin
                        if (!turn_on_c) begin
                            pe_n   = target_c;
                            comm_n = |target_c;
                        end else begin
                            pe_n    = pe_q & target_c;
                            cnt_n   = DT_RELOAD;
                            state_n = DT_DEAD;
                        end
                    end
                end
                DT_DEAD: begin
                    pe_n = pe_q & target_c;
                    // Restart takes priority over expiry so a late target
                    // change can never skip its own dead interval.
                    if (tgt_changed_c && turn_on_c) begin
                        cnt_n = DT_RELOAD;
                    end else if (cnt_q != '0) begin
                        cnt_n = cnt_q - CNT_W'(1);
                    end else begin
                        pe_n    = target_c;
                        state_n = DT_RUN;
                        comm_n  = |target_c;
                    end
                end
                default: begin
                    state_n = DT_RUN;
                    pe_n    = '0;
                end
            endcase
        end
    end

    // Dead-time state and registered gate/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DT_RUN;
            cnt_q   <= '0;
            pe_q    <= '0;
            tgt_q   <= '0;
            comm_q  <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            pe_q    <= pe_n;
            tgt_q   <= target_c;
            comm_q  <= comm_n;
            dead_q  <= (state_n == DT_DEAD);
        end
    end

    assign bus.phase_enable = pe_q;
    assign bus.sector       = sector_q;
    assign bus.commutated   = comm_q;
    assign bus.hall_fault   = fault_q;
    assign bus.in_deadtime  = dead_q;

endmodule

// File: tb/tb_bldc_deadtime_commutator.sv
// Bench for bldc_deadtime_commutator: directed scenarios plus a random
// dir/hall run, every cycle compared against a timestamp-based model.
module tb_bldc_deadtime_commutator;
    import bldc_deadtime_commutator_pkg::*;

    localparam int DT = 16;
    localparam int HF = 4;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    bldc_deadtime_commutator_if bus ();

    bldc_deadtime_commutator #(
        .DEADTIME_CYCLES (DT),
        .HALL_FILTER     (HF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Phase index A=0, B=1, C=2 for the CW hi/lo pair of each sector.
    int cw_hi   [6] = '{0, 0, 1, 1, 2, 2};
    int cw_lo   [6] = '{1, 2, 2, 0, 0, 1};
    int sec_tab [8] = '{7, 5, 3, 4, 1, 0, 2, 7};
    logic [2:0] hall_vals [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    // Reference model state
    int         k;
    logic [2:0] hist [$];
    logic [2:0] m_acc;
    bit         m_valid;
    int         m_sector;
    bit         m_fault;
    logic [5:0] m_pe;
    logic [5:0] m_tgt_prev;
    bit         m_dead;
    bit         m_comm;
    int         m_deadline;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] model_target(rotation_direction_t d, int sec, bit flt);
        int hi;
        int lo;
        if (flt) return 6'd0;
        if (d == DIR_BRAKE) return 6'b000111;
        if (sec > 5 || (d != DIR_CW && d != DIR_CCW)) return 6'd0;
        if (d == DIR_CW) begin
            hi = cw_hi[sec];
            lo = cw_lo[sec];
        end else begin
            hi = cw_lo[sec];
            lo = cw_hi[sec];
        end
        return 6'((1 << (5 - hi)) | (1 << (2 - lo)));
    endfunction

    task automatic model_reset();
        k          = 0;
        hist.delete();
        m_acc      = 3'b000;
        m_valid    = 1'b0;
        m_sector   = 7;
        m_fault    = 1'b0;
        m_pe       = '0;
        m_tgt_prev = '0;
        m_dead     = 1'b0;
        m_comm     = 1'b0;
        m_deadline = 0;
    endtask

    // One rising edge of the model, using the inputs present before the edge.
    task automatic model_edge();
        logic [5:0] t;
        bit         new_on;
        bit         fset;
        bit         all_eq;
        k++;
        hist.push_front(bus.hall_in);
        if (hist.size() > 16) void'(hist.pop_back());

        t      = model_target(bus.dir, m_sector, m_fault);
        new_on = |(t & ~m_pe);
        m_comm = 1'b0;
        if (!m_dead) begin
            if (t != m_pe) begin
                if (!new_on) begin
                    m_pe   = t;
                    m_comm = (t != 0);
                end else begin
                    m_pe       = m_pe & t;
                    m_dead     = 1'b1;
                    m_deadline = k + DT;
                end
            end
        end else begin
            m_pe = m_pe & t;
            if (t != m_tgt_prev && new_on) begin
                m_deadline = k + DT;
            end else if (k >= m_deadline) begin
                m_pe   = t;
                m_dead = 1'b0;
                m_comm = (t != 0);
            end
        end
        m_tgt_prev = t;

        fset = m_valid && (m_acc == 3'b000 || m_acc == 3'b111)
             && (bus.dir == DIR_CW || bus.dir == DIR_CCW);
        if (fset) m_fault = 1'b1;
        else if (bus.fault_clear) m_fault = 1'b0;

        m_sector = sec_tab[m_acc];

        // Accepted hall: the pins seen two clocks late, stable for HF samples.
        if (hist.size() >= HF + 2) begin
            all_eq = 1'b1;
            for (int j = 3; j < HF + 2; j++) begin
                if (hist[j] != hist[2]) all_eq = 1'b0;
            end
            if (all_eq) begin
                m_acc   = hist[2];
                m_valid = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check("phase_enable", 32'(bus.phase_enable), 32'(m_pe));
        check("sector", 32'(bus.sector), 32'(m_sector));
        check("commutated", 32'(bus.commutated), 32'(m_comm));
        check("hall_fault", 32'(bus.hall_fault), 32'(m_fault));
        check("in_deadtime", 32'(bus.in_deadtime), 32'(m_dead));
        check("hi_lo_exclusion", 32'(bus.phase_enable[5:3] & bus.phase_enable[2:0]), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1);
    end

    initial begin
        int hold;
        int ncomm;
        int r;

        rst_n           = 1'b0;
        bus.dir         = DIR_CW;
        bus.hall_in     = 3'b101;
        bus.fault_clear = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Start-up in sector 0, CW
        repeat (23) step();
        check("startup_off", 32'(bus.phase_enable), 32'd0);
        step();
        check("startup_on", 32'(bus.phase_enable), 32'b100010);
        check("startup_sector", 32'(bus.sector), 32'd0);
        check("startup_comm", 32'(bus.commutated), 32'd1);
        repeat (4) step();

        // Sector 0 -> 1: lo_B falls at once, lo_C waits DT+1 clocks
        bus.hall_in = 3'b100;
        repeat (7) step();
        check("s1_before", 32'(bus.phase_enable), 32'b100010);
        step();
        check("s1_lo_b_off", 32'(bus.phase_enable), 32'b100000);
        check("s1_dead", 32'(bus.in_deadtime), 32'd1);
        repeat (15) step();
        check("s1_still_dead", 32'(bus.phase_enable), 32'b100000);
        step();
        check("s1_lo_c_on", 32'(bus.phase_enable), 32'b100001);
        check("s1_dead_end", 32'(bus.in_deadtime), 32'd0);

        // Short glitch must be ignored
        ncomm = 0;
        bus.hall_in = 3'b110;
        repeat (3) begin step(); if (bus.commutated) ncomm++; end
        bus.hall_in = 3'b100;
        repeat (20) begin step(); if (bus.commutated) ncomm++; end
        check("glitch_sector", 32'(bus.sector), 32'd1);
        check("glitch_pe", 32'(bus.phase_enable), 32'b100001);
        check("glitch_comm", 32'(ncomm), 32'd0);

        // Sector 2 then brake
        bus.hall_in = 3'b110;
        repeat (30) step();
        check("s2_pe", 32'(bus.phase_enable), 32'b010001);
        bus.dir = DIR_BRAKE;
        step();
        check("brake_hi_b_off", 32'(bus.phase_enable), 32'b000001);
        repeat (15) step();
        check("brake_waiting", 32'(bus.phase_enable), 32'b000001);
        step();
        check("brake_on", 32'(bus.phase_enable), 32'b000111);

        // Brake -> none: immediate turn-off
        bus.dir = DIR_NONE;
        step();
        check("none_off", 32'(bus.phase_enable), 32'd0);
        check("none_no_dead", 32'(bus.in_deadtime), 32'd0);

        // Invalid hall fault and its clearing rules
        bus.dir     = DIR_CW;
        bus.hall_in = 3'b111;
        repeat (10) step();
        check("fault_set", 32'(bus.hall_fault), 32'd1);
        check("fault_pe", 32'(bus.phase_enable), 32'd0);
        bus.fault_clear = 1'b1;
        step();
        bus.fault_clear = 1'b0;
        check("fault_clear_ignored", 32'(bus.hall_fault), 32'd1);
        bus.hall_in = 3'b101;
        repeat (8) step();
        check("fault_held", 32'(bus.hall_fault), 32'd1);
        bus.fault_clear = 1'b1;
        step();
        bus.fault_clear = 1'b0;
        check("fault_cleared", 32'(bus.hall_fault), 32'd0);
        repeat (16) step();
        check("refire_wait", 32'(bus.phase_enable), 32'd0);
        step();
        check("refire_on", 32'(bus.phase_enable), 32'b100010);

        // Reset in the middle of a dead interval
        bus.hall_in = 3'b100;
        repeat (10) step();
        check("pre_reset_dead", 32'(bus.in_deadtime), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_pe", 32'(bus.phase_enable), 32'd0);
        check("rst_dead", 32'(bus.in_deadtime), 32'd0);
        check("rst_sector", 32'(bus.sector), 32'd7);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (24) step();
        check("post_reset_on", 32'(bus.phase_enable), 32'b100001);

        // Randomised dir/hall run
        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold == 0) begin
                r = int'($urandom_range(0, 15));
                if (r < 11) begin
                    bus.hall_in = hall_vals[$urandom_range(0, 5)];
                    hold = int'($urandom_range(6, 40));
                end else if (r < 13) begin
                    bus.hall_in = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
                    hold = int'($urandom_range(1, 12));
                end else begin
                    bus.hall_in = hall_vals[$urandom_range(0, 5)];
                    hold = int'($urandom_range(1, 4));
                end
            end
            hold--;
            if ($urandom_range(0, 39) == 0) bus.dir = rotation_direction_t'($urandom_range(0, 3));
            bus.fault_clear = ($urandom_range(0, 7) == 0);
            step();
        end
        bus.fault_clear = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bldc_deadtime_commutator.md
Name: bldc_deadtime_commutator

Overview:
- Parametrised successor to the basic table commutator in the bldc driver path, sitting between hall sensor pins / direction control and the gate-driver outputs.
- Adds hall input synchronisation and glitch filtering, invalid-hall fault detection, sector reporting and programmable dead-time insertion.
- Guarantees that no gate output turns on while a gate being turned off in the same change has not yet finished its dead-time interval.

Parameters:
- DEADTIME_CYCLES, 16: idle clocks inserted before any gate turns on after a change; 0 bypasses dead-time.
- HALL_FILTER, 4: consecutive identical synchronised hall samples required to accept a new hall value; minimum 1.
- CNT_W, $clog2(max(DEADTIME_CYCLES,HALL_FILTER)+1): internal counter width (derived, not overridden).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- dir  in  rotation_direction_t  commanded mode: DIR_NONE, DIR_CW, DIR_CCW, DIR_BRAKE
- hall_in  in  3  raw hall pins {A,B,C}, asynchronous to clk
- fault_clear  in  1  single-cycle pulse that clears hall_fault
- phase_enable  out  6  {hi_A,hi_B,hi_C,lo_A,lo_B,lo_C}
- sector  out  3  accepted sector 0..5; 7 = invalid/none
- commutated  out  1  one-cycle pulse when phase_enable takes a new non-zero target
- hall_fault  out  1  sticky invalid-hall flag
- in_deadtime  out  1  high while the dead-time FSM is in DEAD

Behaviour:
- Reset (async assert, sync release): phase_enable=0, sector=7, commutated=0, hall_fault=0, in_deadtime=0, sync flops=0, filter counter=0, accepted hall=3'b000, FSM=RUN.
- Sync: hall_in passes through 2-flop synchroniser; hall_s lags the pins by 2 clocks.
- Filter: if hall_s differs from the candidate, load the candidate and reset the counter to 1. When the counter reaches HALL_FILTER with hall_s unchanged, the accepted hall updates on that cycle. A pin change held stable therefore affects the accepted hall after 2+HALL_FILTER clocks. Shorter pulses are ignored.
- Sector mapping: HALL_AC→0, HALL_A→1, HALL_AB→2, HALL_B→3, HALL_BC→4, HALL_C→5; 000/111→7. Sector register updates one clock after the accepted hall.
- Fault: accepted hall 000 or 111 while dir is CW/CCW sets hall_fault on the next clock.
  - fault_clear clears it only if the condition is absent; the set condition wins when both occur in the same cycle.
  - While hall_fault=1, target=0.
- Target (combinational):
  - DIR_NONE or fault → 0.
  - DIR_BRAKE → 6'b000111.
  - CW sector s → hi/lo pair: s0 A/B, s1 A/C, s2 B/C, s3 B/A, s4 C/A, s5 C/B.
  - CCW sector s → s0 B/A, s1 C/A, s2 C/B, s3 A/B, s4 A/C, s5 B/C.
  - Invalid sector or invalid dir encoding → 0.
- Dead-time FSM, states RUN and DEAD:
  - RUN, target==phase_enable: hold.
  - RUN, target differs and target&~phase_enable==0 (turn-off only): phase_enable<=target next clock, no dead-time.
  - RUN, target turns any bit on and DEADTIME_CYCLES>0: phase_enable<=phase_enable&target; cnt<=DEADTIME_CYCLES-1; go DEAD.
  - DEAD, cnt>0: cnt decrements each clock; phase_enable tracks phase_enable&target, so further turn-offs apply immediately.
  - DEAD, target changes to a value that turns on a bit currently off: cnt reloads DEADTIME_CYCLES-1 (restart).
  - DEAD, cnt==0: phase_enable<=target; go RUN; commutated pulses if target≠0.
  - DEADTIME_CYCLES==0: RUN applies target directly each clock.
- Timing: newly enabled bits rise DEADTIME_CYCLES+1 clocks after the target change; the disabled bits fall 1 clock after it.
- Invariant (assertable): never hi_X & lo_X for the same phase X.
- dir change mid-DEAD: handled by the same rules; no special case.
- Reset mid-DEAD: outputs go to 0 immediately on rst_n low.

Decomposition:
- Shared bldc types package already holds rotation_direction_t, hall_states_t and the PHASE_* constants. Add:
  - the dt_state_t enum {DT_RUN, DT_DEAD};
  - the SECTOR_INVALID=3'd7 constant;
  - a hall_to_sector function.
- One sub-module: bldc_hall_filter (synchroniser + stability counter + accepted hall output), reused later by speed-estimation blocks.
- Dead-time FSM and target table stay in the top module.

Test Plan:
- Reset, dir=CW, hall_in=HALL_AC held: phase_enable=0 until 2+4+1+16+1 clocks after reset release, then {PHASE_A,PHASE_B}; sector=0; commutated pulses once.
- CW running in sector 0, hall → HALL_A: lo_B falls next clock, lo_C rises 17 clocks after the target change, hi_A stays high throughout; in_deadtime high for 16 clocks.
- Hall glitch to HALL_A for 3 clocks, then back to HALL_AC: accepted hall, sector and phase_enable unchanged; no commutated pulse.
- hall_in=3'b111 for 10 clocks while CW: hall_fault=1, phase_enable=0; fault_clear while 111 persists has no effect; after valid hall plus fault_clear, fault clears and re-enable follows the dead-time rule.
- CW sector 2 ({B,C}) switched to DIR_BRAKE: hi_B falls and lo_C holds; lo_A and lo_B rise after 16 dead clocks.
- DIR_BRAKE → DIR_NONE: all outputs 0 on the next clock, no dead-time; assert the hi/lo exclusion invariant throughout a randomised dir/hall run.
